// File: rtl/alkc_seq.sv
// ALKC carry-flag sequencer for 32-step multiply / non-restoring divide.
// Optional feature macro: ALKC_SEQ_ABORT_EN (abort_h cancels a running sequence).
module alkc_seq (
  input  logic clk_h,
  input  logic reset_l,
  input  logic start_h,
  input  logic op_div_h,
  input  logic stall_l,
  input  logic alu_cout_h,
  input  logic alkc_load_h,
  input  logic alkc_data_h,
  input  logic abort_h,
  output logic alkc_flag_h,
  output logic carry_invert_h,
  output logic quo_bit_h,
  output logic busy_h,
  output logic done_h
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] STEP = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0] state;
  logic [4:0] count;
  logic       div_op;
  logic       abort_act;

`ifdef ALKC_SEQ_ABORT_EN
  assign abort_act = abort_h && (state != IDLE);
`else
  logic unused_abort;
  assign unused_abort = abort_h;
  assign abort_act    = 1'b0;
`endif

  // Abort wins over stall so a frozen pipeline can still be cancelled.
  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      state          <= IDLE;
      count          <= 5'd0;
      div_op         <= 1'b0;
      alkc_flag_h    <= 1'b0;
      carry_invert_h <= 1'b0;
      quo_bit_h      <= 1'b0;
    end else if (abort_act) begin
      state          <= IDLE;
      count          <= 5'd0;
      alkc_flag_h    <= 1'b0;
      carry_invert_h <= 1'b0;
      quo_bit_h      <= 1'b0;
    end else if (stall_l) begin
      case (state)
        IDLE: begin
          if (start_h) begin
            state          <= STEP;
            count          <= 5'd31;
            div_op         <= op_div_h;
            alkc_flag_h    <= op_div_h;
            carry_invert_h <= op_div_h;
          end else if (alkc_load_h) begin
            alkc_flag_h <= alkc_data_h;
          end
        end
        STEP: begin
          alkc_flag_h    <= alu_cout_h;
          carry_invert_h <= div_op & alu_cout_h;
          quo_bit_h      <= div_op & alu_cout_h;
          // A negative final divide remainder needs one restore cycle.
          if (count == 5'd0)
            state <= (div_op && !alu_cout_h) ? FIX : DONE;
          else
            count <= count - 5'd1;
        end
        FIX: begin
          carry_invert_h <= 1'b0;
          alkc_flag_h    <= 1'b0;
          state          <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_h = (state == STEP) || (state == FIX);
  assign done_h = (state == DONE) && !abort_act;

endmodule

// File: tb/tb_alkc_seq.sv
// Randomized self-checking bench for alkc_seq; each sequence is predicted
// from its per-step carry list (flag tracks cout, FIX on negative divide).
module tb_alkc_seq;

  logic clk_h = 1'b0;
  logic reset_l, start_h, op_div_h, stall_l, alu_cout_h;
  logic alkc_load_h, alkc_data_h, abort_h;
  logic alkc_flag_h, carry_invert_h, quo_bit_h, busy_h, done_h;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_flag = 1'b0;
  logic exp_ci   = 1'b0;
  logic exp_quo  = 1'b0;

  alkc_seq dut (
    .clk_h(clk_h), .reset_l(reset_l), .start_h(start_h), .op_div_h(op_div_h),
    .stall_l(stall_l), .alu_cout_h(alu_cout_h), .alkc_load_h(alkc_load_h),
    .alkc_data_h(alkc_data_h), .abort_h(abort_h), .alkc_flag_h(alkc_flag_h),
    .carry_invert_h(carry_invert_h), .quo_bit_h(quo_bit_h), .busy_h(busy_h),
    .done_h(done_h)
  );

  always #5 clk_h = ~clk_h;

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  function automatic logic [4:0] obs();
    return {alkc_flag_h, carry_invert_h, quo_bit_h, busy_h, done_h};
  endfunction

  // Full 32-step sequence: start, optional stall at one step, optional stall in DONE.
  task automatic run_sequence(input logic div, input int mode, input int stall_step,
                              input int stall_len, input int done_stall, input string tag);
    logic [31:0] cout;
    logic fix;
    logic [4:0] exp;
    for (int k = 0; k < 32; k++) begin
      case (mode)
        0: cout[k] = 1'($urandom);
        1: cout[k] = (k % 2 == 0);
        2: cout[k] = 1'b1;
        default: cout[k] = (k != 31);
      endcase
    end
    fix = div && !cout[31];
    start_h = 1'b1; op_div_h = div; stall_l = 1'b1;
    alkc_load_h = 1'($urandom); alkc_data_h = 1'($urandom);
    tick();
    exp_flag = div; exp_ci = div;
    exp = {exp_flag, exp_ci, exp_quo, 2'b10};
    n_cmp++;
    if (obs() !== exp) begin
      n_err++; $display("FAIL %s start: got %b expected %b", tag, obs(), exp);
    end
    for (int k = 0; k < 32; k++) begin
      alu_cout_h = cout[k]; start_h = 1'($urandom); op_div_h = 1'($urandom);
      alkc_load_h = 1'($urandom); alkc_data_h = 1'($urandom);
      if (k == stall_step) begin
        for (int s = 0; s < stall_len; s++) begin
          stall_l = 1'b0;
          tick();
          exp = {exp_flag, exp_ci, exp_quo, 2'b10};
          n_cmp++;
          if (obs() !== exp) begin
            n_err++; $display("FAIL %s stall step %0d: got %b expected %b", tag, k, obs(), exp);
          end
        end
        stall_l = 1'b1;
      end
      tick();
      exp_flag = cout[k]; exp_ci = div & cout[k]; exp_quo = div & cout[k];
      exp = {exp_flag, exp_ci, exp_quo, (k < 31) || fix, (k == 31) && !fix};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++; $display("FAIL %s step %0d: got %b expected %b", tag, k, obs(), exp);
      end
    end
    start_h = 1'b0; alkc_load_h = 1'b0;
    if (fix) begin
      tick();
      exp_flag = 1'b0; exp_ci = 1'b0;
      exp = {exp_flag, exp_ci, exp_quo, 2'b01};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++; $display("FAIL %s done after fix: got %b expected %b", tag, obs(), exp);
      end
    end
    for (int s = 0; s < done_stall; s++) begin
      stall_l = 1'b0; alkc_load_h = 1'b1; alkc_data_h = ~exp_flag;
      tick();
      exp = {exp_flag, exp_ci, exp_quo, 2'b01};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++; $display("FAIL %s done stall %0d: got %b expected %b", tag, s, obs(), exp);
      end
    end
    stall_l = 1'b1; alkc_load_h = 1'b0;
    tick();
    exp = {exp_flag, exp_ci, exp_quo, 2'b00};
    n_cmp++;
    if (obs() !== exp) begin
      n_err++; $display("FAIL %s idle: got %b expected %b", tag, obs(), exp);
    end
    $display("seq %s div=%0b mode=%0d fix=%0b stall=%0d/%0d", tag, div, mode, fix, stall_len, done_stall);
  endtask

  task automatic test_reset();
    start_h = 1'b0; op_div_h = 1'b0; stall_l = 1'b1; alu_cout_h = 1'b0;
    alkc_load_h = 1'b0; alkc_data_h = 1'b0; abort_h = 1'b0; reset_l = 1'b0;
    #2;
    n_cmp++;
    if (obs() !== 5'b0) begin
      n_err++; $display("FAIL reset: got %b expected 00000", obs());
    end
    tick(); tick();
    reset_l = 1'b1;
    exp_flag = 1'b0; exp_ci = 1'b0; exp_quo = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_load();
    logic d, st;
    for (int i = 0; i < 8; i++) begin
      d = 1'($urandom); st = (i % 3 != 2);
      alkc_load_h = 1'b1; alkc_data_h = d; stall_l = st; abort_h = 1'($urandom);
      tick();
      if (st) exp_flag = d;
      n_cmp++;
      if (obs() !== {exp_flag, exp_ci, exp_quo, 2'b00}) begin
        n_err++; $display("FAIL load %0d: got %b expected %b", i, obs(), {exp_flag, exp_ci, exp_quo, 2'b00});
      end
      $display("load data=%0b stall_l=%0b flag=%0b", d, st, alkc_flag_h);
    end
    alkc_load_h = 1'b0; stall_l = 1'b1; abort_h = 1'b0;
  endtask

  task automatic test_multiply();    run_sequence(1'b0, 1, -1, 0, 0, "mul_alt");   endtask
  task automatic test_divide_pass(); run_sequence(1'b1, 2, -1, 0, 0, "div_pass");  endtask
  task automatic test_divide_fix();  run_sequence(1'b1, 3, -1, 0, 0, "div_fix");   endtask
  task automatic test_stall();       run_sequence(1'($urandom), 0, 10, 3, 3, "stall"); endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_sequence(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "b2b");
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    start_h = 1'b1; op_div_h = 1'($urandom); stall_l = 1'b1;
    tick();
    start_h = 1'b0;
    for (int k = 0; k < 5; k++) begin alu_cout_h = 1'($urandom); tick(); end
    reset_l = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 5'b0) begin
      n_err++; $display("FAIL reset_mid: got %b expected 00000", obs());
    end
    for (int c = 0; c < 3; c++) begin tick(); seen |= done_h | busy_h; end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL reset_mid hold: got activity %b expected 0", seen);
    end
    reset_l = 1'b1;
    exp_flag = 1'b0; exp_ci = 1'b0; exp_quo = 1'b0;
    $display("reset mid-sequence checked");
    run_sequence(1'($urandom), 0, -1, 0, 0, "restart");
  endtask

  task automatic test_abort();
    int cyc;
    start_h = 1'b1; op_div_h = 1'b0; stall_l = 1'b1; alu_cout_h = 1'b1;
    tick();
    cyc = 1; start_h = 1'b0;
    for (int k = 0; k < 5; k++) begin tick(); cyc++; end
    abort_h = 1'b1;
    tick();
    cyc++;
    abort_h = 1'b0;
`ifdef ALKC_SEQ_ABORT_EN
    begin
      logic seen = 1'b0;
      n_cmp++;
      if (obs() !== 5'b0) begin
        n_err++; $display("FAIL abort: got %b expected 00000", obs());
      end
      for (int c = 0; c < 40; c++) begin tick(); seen |= done_h; end
      n_cmp++;
      if (seen !== 1'b0) begin
        n_err++; $display("FAIL abort no_done: got %b expected 0", seen);
      end
      exp_flag = 1'b0; exp_ci = 1'b0; exp_quo = 1'b0;
    end
`else
    while (!done_h && cyc < 60) begin tick(); cyc++; end
    n_cmp++;
    if (cyc !== 33) begin
      n_err++; $display("FAIL abort ignored latency: got cycle %0d expected 33", cyc);
    end
    exp_flag = 1'b1; exp_ci = 1'b0; exp_quo = 1'b0;
    n_cmp++;
    if (obs() !== 5'b10001) begin
      n_err++; $display("FAIL abort ignored outputs: got %b expected 10001", obs());
    end
    tick();
`endif
    $display("abort at step 5 checked");
  endtask

  initial begin
    test_reset();
    test_load();
    test_multiply();
    test_divide_pass();
    test_divide_fix();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_abort();
    run_sequence(1'($urandom), 0, -1, 0, 1, "post_abort");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
